binary_adder_game: RTL and testbench
====================================

Name: binary_adder_game

Overview:
- Switch-driven 4-bit binary arithmetic trainer.
- Operands A and B and a 2-bit mode come from board switches; the result and carry/borrow flag drive LEDs combinationally, and an 8x8 grid image is produced for display.
- A button-triggered "check" compares the player's switch-entered answer against the true result and maintains a saturating score.
- Sits between board I/O debouncing (which supplies btn_pulse) and the LED/matrix drivers.

Parameters:
- USE_STRUCTURAL, 0: 0 = behavioural +/- operators; 1 = ripple-carry adder built from full adders (subtraction as A + ~B + 1). Both must give bit-identical outputs.

Ports:
- clk  input  1  system clock (50 MHz nominal)
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
- btn_pulse  input  5  single-cycle button pulses; [0]=check, [1]=clear score, [4:2] ignored
- sw  input  16  [3:0]=A, [7:4]=B, [9:8]=mode, [10] unused, [15:11]=player guess {flag, value[3:0]}
- led  output  16  [7:0]=displayed value, [8]=carry/borrow flag, [15:9]=0
- grid  output  64  8x8 pixel image, bit index = 8*row + col
- check_ok  output  1  registered result of last check
- score  output  8  registered count of correct checks

Behaviour:
- Arithmetic is purely combinational from sw, with no clock latency. led must be valid immediately after sw changes, before any clock edge.
- The 5-bit result R = {flag, val[3:0]} is formed per mode:
  - mode 00: val = A, flag = 0.
  - mode 01: val = B, flag = 0.
  - mode 10: {flag, val} = A + B (5-bit). flag = carry-out. Example: F+F → val E, flag 1.
  - mode 11: {flag, val} = A − B (5-bit two's-complement wrap). flag = borrow, i.e. 1 iff A < B. Example: 0−F → val 1, flag 1.
- led[7:4] = 0, led[7:0] = {4'b0, val}, led[8] = flag, led[15:9] = 0. All led bits are combinational and unaffected by reset.
- grid is combinational and unaffected by reset. Layout:
  - row 0 cols 3:0 = A
  - row 1 cols 3:0 = B
  - row 2 cols 4:0 = R
  - row 3 cols 1:0 = mode
  - row 7 col 0 = check_ok
  - all other bits 0
- Registered state (check_ok, score):
  - On reset (rst = 0 at a rising edge): check_ok = 0, score = 0. Reset overrides buttons.
  - btn_pulse[0] = 1 at an edge: check_ok <= (sw[15:11] == R). If they match, score <= score + 1, saturating at 255.
  - btn_pulse[1] = 1 at an edge: score <= 0 and check_ok <= 0. This takes priority over btn_pulse[0] in the same cycle.
  - Otherwise check_ok and score hold their values.
- btn_pulse held high for multiple cycles counts once per cycle; upstream guarantees single-cycle pulses.
- Reset in mid-operation clears only the registers; the combinational outputs keep tracking sw.

Decomposition:
- Package binary_adder_game_pkg holds:
  - mode enum: MODE_SHOW_A = 2'b00, MODE_SHOW_B = 2'b01, MODE_ADD = 2'b10, MODE_SUB = 2'b11
  - switch field index constants
  - button index constants BTN_CHECK = 0, BTN_CLEAR = 1
  - SCORE_MAX = 8'd255
- One sub-module, ripple_adder4: inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout. It is built from four full-adder bit slices and is instantiated only when USE_STRUCTURAL = 1.

Test Plan:
- Mode 00/01 sweep: for A (or B) = 0..15 with the other operand 0 → led[7:0] equals that operand, led[8] = 0.
- Mode 10 grid sweep: A, B ∈ {0, 3, 6, 9, 12, 15} → led[3:0] = (A+B) mod 16, led[8] = (A+B ≥ 16); corner case F+F → led = 0x10E.
- Mode 11 grid sweep with the same values → led[3:0] = (A−B) mod 16, led[8] = (A < B); corner case A = 0, B = F → led = 0x101; A = 9, B = 3 → led = 0x006.
- Check/score: reset, then A = 7, B = 9, mode 10, guess = 5'b10000, pulse check → check_ok = 1, score = 1. Then guess = 5'b00000, pulse check → check_ok = 0, score = 1.
- Saturation and priority:
  - 256 correct checks → score = 255.
  - Pulse check and clear together → score = 0, check_ok = 0.
  - rst = 0 for one edge mid-run → check_ok = 0, score = 0 while led still follows sw.
- Repeat all of the above with USE_STRUCTURAL = 1 and require identical led, grid, check_ok and score every cycle.

Source files
------------

// File: rtl/binary_adder_game_pkg.sv
// Shared types and constants for the binary arithmetic trainer.
package binary_adder_game_pkg;

    // Operating mode selected by sw[9:8]
    typedef enum logic [1:0] {
        MODE_SHOW_A = 2'b00,
        MODE_SHOW_B = 2'b01,
        MODE_ADD    = 2'b10,
        MODE_SUB    = 2'b11
    } mode_e;

    // Switch field positions
    localparam int SW_A_LSB     = 0;
    localparam int SW_B_LSB     = 4;
    localparam int SW_MODE_LSB  = 8;
    localparam int SW_GUESS_LSB = 11;
    localparam int OPERAND_W    = 4;
    localparam int RESULT_W     = 5;

    // Button pulse positions
    localparam int BTN_CHECK = 0;
    localparam int BTN_CLEAR = 1;

    localparam logic [7:0] SCORE_MAX = 8'd255;

    // LED word for a result: value on [3:0], flag on [8], everything else dark
    function automatic logic [15:0] pack_led(input logic [RESULT_W-1:0] r);
        pack_led = {7'b0, r[4], 4'b0, r[3:0]};
    endfunction

endpackage

// File: rtl/binary_adder_game_ripple_adder4.sv
// 4-bit ripple-carry adder made of four full-adder bit slices.
module ripple_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_carry;

    assign w_carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            // One full adder: sum bit and carry to the next slice
            assign sum[gi]        = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_carry[4];

endmodule

// File: rtl/binary_adder_game.sv
// Switch-driven 4-bit add/subtract trainer: combinational LED and grid
// image, plus a registered answer check with a saturating score.
module binary_adder_game
    import binary_adder_game_pkg::*;
#(
    parameter int USE_STRUCTURAL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn_pulse,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [63:0] grid,
    output logic        check_ok,
    output logic [7:0]  score
);

    logic [OPERAND_W-1:0] w_a;
    logic [OPERAND_W-1:0] w_b;
    mode_e                w_mode;
    logic [RESULT_W-1:0]  w_guess;
    logic [RESULT_W-1:0]  w_result;
    logic [OPERAND_W-1:0] w_add_val;
    logic                 w_add_flag;
    logic [OPERAND_W-1:0] w_sub_val;
    logic                 w_sub_flag;
    logic                 w_guess_ok;
    logic                 w_unused;

    logic                 r_check_ok;
    logic [7:0]           r_score;

    assign w_a     = sw[SW_A_LSB +: OPERAND_W];
    assign w_b     = sw[SW_B_LSB +: OPERAND_W];
    assign w_mode  = mode_e'(sw[SW_MODE_LSB +: 2]);
    assign w_guess = sw[SW_GUESS_LSB +: RESULT_W];

    // sw[10] and the upper buttons have no function
    assign w_unused = ^{sw[10], btn_pulse[4:2]};

    generate
        if (USE_STRUCTURAL != 0) begin : g_struct
            logic w_sub_cout;

            ripple_adder4 u_add (
                .a    (w_a),
                .b    (w_b),
                .cin  (1'b0),
                .sum  (w_add_val),
                .cout (w_add_flag)
            );

            // A - B as A + ~B + 1; a carry out means no borrow occurred
            ripple_adder4 u_sub (
                .a    (w_a),
                .b    (~w_b),
                .cin  (1'b1),
                .sum  (w_sub_val),
                .cout (w_sub_cout)
            );

            assign w_sub_flag = ~w_sub_cout;
        end else begin : g_beh
            logic [RESULT_W-1:0] w_sum5;
            logic [RESULT_W-1:0] w_diff5;

            assign w_sum5     = {1'b0, w_a} + {1'b0, w_b};
            // Zero-extended subtraction sets bit 4 exactly when A < B
            assign w_diff5    = {1'b0, w_a} - {1'b0, w_b};
            assign w_add_val  = w_sum5[3:0];
            assign w_add_flag = w_sum5[4];
            assign w_sub_val  = w_diff5[3:0];
            assign w_sub_flag = w_diff5[4];
        end
    endgenerate

    // Select the displayed result {flag, value} for the current mode
    always_comb begin
        w_result = '0;
        case (w_mode)
            MODE_SHOW_A: w_result = {1'b0, w_a};
            MODE_SHOW_B: w_result = {1'b0, w_b};
            MODE_ADD:    w_result = {w_add_flag, w_add_val};
            MODE_SUB:    w_result = {w_sub_flag, w_sub_val};
            default:     w_result = '0;
        endcase
    end

    assign led        = pack_led(w_result);
    assign w_guess_ok = (w_guess == w_result);

    // Build the 8x8 image; bit index is 8*row + col
    always_comb begin
        grid         = '0;
        grid[3:0]    = w_a;
        grid[11:8]   = w_b;
        grid[20:16]  = w_result;
        grid[25:24]  = sw[SW_MODE_LSB +: 2];
        grid[56]     = r_check_ok;
    end

    // Check/clear handling; clear wins over check, reset wins over both
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_check_ok <= 1'b0;
            r_score    <= 8'd0;
        end else if (btn_pulse[BTN_CLEAR]) begin
            r_check_ok <= 1'b0;
            r_score    <= 8'd0;
        end else if (btn_pulse[BTN_CHECK]) begin
            r_check_ok <= w_guess_ok;
            if (w_guess_ok && (r_score != SCORE_MAX)) begin
                r_score <= r_score + 8'd1;
            end
        end
    end

    assign check_ok = r_check_ok;
    assign score    = r_score;

endmodule

// File: tb/tb_binary_adder_game.sv
// Bench for binary_adder_game: behavioural and structural builds run side
// by side against a reference model of the trainer rules.
module tb_binary_adder_game;

    logic        clk;
    logic        rst;
    logic [4:0]  btn_pulse;
    logic [15:0] sw;

    logic [15:0] led_b, led_s;
    logic [63:0] grid_b, grid_s;
    logic        ok_b, ok_s;
    logic [7:0]  score_b, score_s;

    int checks;
    int failures;
    bit monitor_on;

    logic [95:0] exp_q[$];

    // Reference state
    bit model_ok;
    int model_score;

    binary_adder_game #(.USE_STRUCTURAL(0)) dut_beh (
        .clk       (clk),
        .rst       (rst),
        .btn_pulse (btn_pulse),
        .sw        (sw),
        .led       (led_b),
        .grid      (grid_b),
        .check_ok  (ok_b),
        .score     (score_b)
    );

    binary_adder_game #(.USE_STRUCTURAL(1)) dut_str (
        .clk       (clk),
        .rst       (rst),
        .btn_pulse (btn_pulse),
        .sw        (sw),
        .led       (led_s),
        .grid      (grid_s),
        .check_ok  (ok_s),
        .score     (score_s)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Scoreboard: expected value goes through the queue, then is compared
    task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        logic [95:0] e;
        exp_q.push_back(exp);
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
        end
    endtask

    // Reference result {flag, value} from the trainer rules
    function automatic logic [4:0] model_r(input int a, input int b, input int m);
        logic [4:0] r;
        int s;
        r = '0;
        case (m)
            0: r = 5'(a);
            1: r = 5'(b);
            2: begin
                s = a + b;
                r[3:0] = 4'(s % 16);
                r[4]   = (s >= 16);
            end
            default: begin
                s = a - b;
                r[3:0] = 4'((s + 16) % 16);
                r[4]   = (a < b);
            end
        endcase
        return r;
    endfunction

    function automatic logic [63:0] model_grid(input int a, input int b, input int m, input bit ok);
        logic [63:0] g;
        logic [4:0]  r;
        g = '0;
        r = model_r(a, b, m);
        for (int i = 0; i < 4; i++) begin
            g[0 * 8 + i] = ((a >> i) & 1) != 0;
            g[1 * 8 + i] = ((b >> i) & 1) != 0;
        end
        for (int i = 0; i < 5; i++) g[2 * 8 + i] = r[i];
        for (int i = 0; i < 2; i++) g[3 * 8 + i] = ((m >> i) & 1) != 0;
        g[7 * 8 + 0] = ok;
        return g;
    endfunction

    // Driver: set switches
    task automatic set_sw(input int a, input int b, input int m, input int guess);
        sw = {5'(guess), 1'b0, 2'(m), 4'(b), 4'(a)};
    endtask

    // Compare combinational outputs of both builds against the model
    task automatic check_comb(input string tag);
        int a, b, m;
        logic [4:0]  r;
        logic [15:0] el;
        logic [63:0] eg;
        #1;
        a = int'(sw[3:0]);
        b = int'(sw[7:4]);
        m = int'(sw[9:8]);
        r = model_r(a, b, m);
        el = '0;
        el[3:0] = r[3:0];
        el[8]   = r[4];
        eg = model_grid(a, b, m, model_ok);
        check_val({tag, "_led_beh"}, 96'(led_b), 96'(el));
        check_val({tag, "_led_str"}, 96'(led_s), 96'(el));
        check_val({tag, "_grid_beh"}, 96'(grid_b), 96'(eg));
        check_val({tag, "_grid_str"}, 96'(grid_s), 96'(eg));
    endtask

    task automatic check_regs(input string tag);
        check_val({tag, "_ok_beh"}, 96'(ok_b), 96'(model_ok));
        check_val({tag, "_ok_str"}, 96'(ok_s), 96'(model_ok));
        check_val({tag, "_score_beh"}, 96'(score_b), 96'(model_score));
        check_val({tag, "_score_str"}, 96'(score_s), 96'(model_score));
    endtask

    // Driver: one-cycle button pulse, then update model and compare
    task automatic pulse(input logic [4:0] btn, input string tag);
        logic [4:0] r;
        @(negedge clk);
        btn_pulse = btn;
        @(negedge clk);
        btn_pulse = '0;
        r = model_r(int'(sw[3:0]), int'(sw[7:4]), int'(sw[9:8]));
        if (btn[1]) begin
            model_ok    = 1'b0;
            model_score = 0;
        end else if (btn[0]) begin
            model_ok = (sw[15:11] == r);
            if (model_ok && model_score < 255) model_score++;
        end
        check_regs(tag);
    endtask

    // Driver: a single reset edge
    task automatic reset_edge(input string tag);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_ok    = 1'b0;
        model_score = 0;
        check_regs(tag);
    endtask

    // Both builds must agree on every output every cycle
    always @(posedge clk) begin
        #5;
        if (monitor_on) begin
            check_val("cross_build", {7'b0, led_b, grid_b, ok_b, score_b},
                      {7'b0, led_s, grid_s, ok_s, score_s});
        end
    end

    int vals[6] = '{0, 3, 6, 9, 12, 15};

    initial begin
        logic [4:0] r;
        int a, b, m, sel;
        logic [4:0] btn;
        checks      = 0;
        failures    = 0;
        monitor_on  = 1'b0;
        model_ok    = 1'b0;
        model_score = 0;
        rst         = 1'b0;
        btn_pulse   = '0;
        sw          = '0;

        // Reset
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_regs("reset");
        check_comb("reset_comb");
        monitor_on = 1'b1;

        // Mode 00 / 01 sweeps
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_sw(i, 0, 0, 0);
            check_comb($sformatf("show_a_%0d", i));
            @(negedge clk);
            set_sw(0, i, 1, 0);
            check_comb($sformatf("show_b_%0d", i));
        end

        // Add / subtract grid sweeps
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                @(negedge clk);
                set_sw(vals[i], vals[j], 2, 0);
                check_comb($sformatf("add_%0d_%0d", vals[i], vals[j]));
                @(negedge clk);
                set_sw(vals[i], vals[j], 3, 0);
                check_comb($sformatf("sub_%0d_%0d", vals[i], vals[j]));
            end
        end

        // Corner cases against literal LED words
        @(negedge clk);
        set_sw(15, 15, 2, 0);
        #1;
        check_val("corner_f_plus_f", 96'(led_b), 96'(16'h010E));
        check_val("corner_f_plus_f_str", 96'(led_s), 96'(16'h010E));
        @(negedge clk);
        set_sw(0, 15, 3, 0);
        #1;
        check_val("corner_0_minus_f", 96'(led_b), 96'(16'h0101));
        check_val("corner_0_minus_f_str", 96'(led_s), 96'(16'h0101));
        @(negedge clk);
        set_sw(9, 3, 3, 0);
        #1;
        check_val("corner_9_minus_3", 96'(led_b), 96'(16'h0006));
        check_val("corner_9_minus_3_str", 96'(led_s), 96'(16'h0006));

        // Directed check/score
        reset_edge("score_reset");
        @(negedge clk);
        set_sw(7, 9, 2, 5'b10000);
        pulse(5'b00001, "check_right");
        check_val("check_right_ok_lit", 96'(ok_b), 96'(1));
        check_val("check_right_score_lit", 96'(score_b), 96'(1));
        check_comb("grid_after_right");
        @(negedge clk);
        set_sw(7, 9, 2, 5'b00000);
        pulse(5'b00001, "check_wrong");
        check_val("check_wrong_ok_lit", 96'(ok_b), 96'(0));
        check_val("check_wrong_score_lit", 96'(score_b), 96'(1));

        // Randomized mixture of switches and buttons
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            m = int'($urandom_range(0, 3));
            r = model_r(a, b, m);
            if ($urandom_range(0, 1) == 1) set_sw(a, b, m, int'(r));
            else set_sw(a, b, m, int'($urandom_range(0, 31)));
            sw[10] = 1'($urandom_range(0, 1));
            check_comb($sformatf("rand_comb_%0d", k));
            sel = int'($urandom_range(0, 9));
            btn = 5'($urandom_range(0, 7)) << 2;
            if (sel < 6) btn[0] = 1'b1;
            else if (sel == 6) btn[1] = 1'b1;
            else if (sel == 7) btn[1:0] = 2'b11;
            pulse(btn, $sformatf("rand_regs_%0d", k));
        end

        // Saturation
        pulse(5'b00010, "sat_clear");
        @(negedge clk);
        set_sw(5, 4, 2, 9);
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            btn_pulse = 5'b00001;
        end
        @(negedge clk);
        btn_pulse = '0;
        model_ok    = 1'b1;
        model_score = 255;
        check_val("sat_score_lit", 96'(score_b), 96'(255));
        check_regs("sat_256");
        pulse(5'b00001, "sat_hold");

        // Clear beats check
        pulse(5'b00011, "clear_priority");
        check_val("clear_priority_lit", 96'(score_s), 96'(0));

        // Reset mid-run while switches keep moving
        pulse(5'b00001, "pre_reset_1");
        pulse(5'b00001, "pre_reset_2");
        @(negedge clk);
        rst = 1'b0;
        set_sw(12, 9, 3, 0);
        check_comb("during_reset_comb");
        @(negedge clk);
        rst = 1'b1;
        model_ok    = 1'b0;
        model_score = 0;
        check_regs("mid_reset");
        set_sw(10, 11, 2, 0);
        check_comb("after_reset_comb");

        @(negedge clk);
        monitor_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
